// File: rtl/timer_control.sv
// timer_control: button edge detection, run/pause/alarm sequencing, target match and lap capture.
// Lap capture is compiled in only when TIMER_LAP_EN is defined; otherwise lap outputs read 0.
module timer_control #(
  parameter int W           = 6,
  parameter int ALARM_TICKS = 10
) (
  input  logic         clk_out_led,
  input  logic         reset,
  input  logic         btn_start,
  input  logic         btn_clear,
  input  logic         btn_lap,
  input  logic [W-1:0] sec_val,
  input  logic [W-1:0] min_val,
  input  logic [W-1:0] target_sec,
  input  logic [W-1:0] target_min,
  output logic         pauza,
  output logic         clr_cnt,
  output logic         alarm,
  output logic [1:0]   state,
  output logic [W-1:0] lap_sec,
  output logic [W-1:0] lap_min,
  output logic         lap_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_ALARM = 2'd3;
  localparam logic [7:0] ALARM_LOAD = 8'(ALARM_TICKS - 1);

  logic       r_start_q;
  logic       r_clear_q;
  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic [7:0] r_alarm_cnt;
  logic [7:0] w_alarm_cnt_next;
  logic       r_clr_cnt;
  logic       w_clr_cnt_next;
  logic       w_start_ev;
  logic       w_clear_ev;
  logic       w_hit;

  always_ff @(posedge clk_out_led) begin
    if (reset) begin
      r_start_q <= 1'b0;
      r_clear_q <= 1'b0;
    end else begin
      r_start_q <= btn_start;
      r_clear_q <= btn_clear;
    end
  end

  assign w_start_ev = btn_start & ~r_start_q;
  assign w_clear_ev = btn_clear & ~r_clear_q;
  // A 0:00 target never matches, so the chain free-runs through its own wrap.
  assign w_hit = (r_state == S_RUN) &&
                 ({min_val, sec_val} == {target_min, target_sec}) &&
                 (|{target_min, target_sec});

  always_ff @(posedge clk_out_led) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_alarm_cnt <= 8'd0;
      r_clr_cnt   <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_alarm_cnt <= w_alarm_cnt_next;
      r_clr_cnt   <= w_clr_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_alarm_cnt_next = r_alarm_cnt;
    w_clr_cnt_next   = 1'b0;
    if (w_clear_ev) begin
      w_state_next     = S_IDLE;
      w_alarm_cnt_next = 8'd0;
      w_clr_cnt_next   = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ev) w_state_next = S_RUN;
        end
        S_RUN: begin
          if (w_hit) begin
            w_state_next     = S_ALARM;
            w_alarm_cnt_next = ALARM_LOAD;
          end else if (w_start_ev) begin
            w_state_next = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (w_start_ev) w_state_next = S_RUN;
        end
        default: begin
          if (w_start_ev || (r_alarm_cnt == 8'd0)) begin
            w_state_next   = S_IDLE;
            w_clr_cnt_next = 1'b1;
          end else begin
            w_alarm_cnt_next = r_alarm_cnt - 8'd1;
          end
        end
      endcase
    end
  end

  // pauza is combinational so the chain stops on the very cycle it reaches the target.
  always_comb begin
    pauza   = (r_state != S_RUN) | w_hit;
    alarm   = (r_state == S_ALARM);
    state   = r_state;
    clr_cnt = r_clr_cnt;
  end

`ifdef TIMER_LAP_EN
  logic         r_lap_q;
  logic [W-1:0] r_lap_sec;
  logic [W-1:0] r_lap_min;
  logic         r_lap_valid;
  logic         w_lap_ev;

  assign w_lap_ev = btn_lap & ~r_lap_q;

  always_ff @(posedge clk_out_led) begin
    if (reset) begin
      r_lap_q     <= 1'b0;
      r_lap_sec   <= '0;
      r_lap_min   <= '0;
      r_lap_valid <= 1'b0;
    end else begin
      r_lap_q <= btn_lap;
      if (w_clear_ev) begin
        r_lap_valid <= 1'b0;
      end else if (w_lap_ev && (r_state == S_RUN) && !w_hit) begin
        r_lap_sec   <= sec_val;
        r_lap_min   <= min_val;
        r_lap_valid <= 1'b1;
      end
    end
  end

  assign lap_sec   = r_lap_sec;
  assign lap_min   = r_lap_min;
  assign lap_valid = r_lap_valid;
`else
  logic w_unused_lap;
  assign w_unused_lap = btn_lap;
  assign lap_sec      = '0;
  assign lap_min      = '0;
  assign lap_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_timer_control.sv
// Self-checking bench for timer_control: directed scenarios plus randomized buttons,
// compared every cycle against a behavioural model; lap checks follow TIMER_LAP_EN.
module tb_timer_control;

  localparam int W           = 6;
  localparam int ALARM_TICKS = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         btn_start = 1'b0;
  logic         btn_clear = 1'b0;
  logic         btn_lap = 1'b0;
  logic [W-1:0] sec_val = '0;
  logic [W-1:0] min_val = '0;
  logic [W-1:0] target_sec = '0;
  logic [W-1:0] target_min = '0;
  logic         pauza, clr_cnt, alarm, lap_valid;
  logic [1:0]   state;
  logic [W-1:0] lap_sec, lap_min;

  int n_checks = 0;
  int n_errors = 0;

  timer_control #(.W(W), .ALARM_TICKS(ALARM_TICKS)) dut (
    .clk_out_led (clk),
    .reset       (reset),
    .btn_start   (btn_start),
    .btn_clear   (btn_clear),
    .btn_lap     (btn_lap),
    .sec_val     (sec_val),
    .min_val     (min_val),
    .target_sec  (target_sec),
    .target_min  (target_min),
    .pauza       (pauza),
    .clr_cnt     (clr_cnt),
    .alarm       (alarm),
    .state       (state),
    .lap_sec     (lap_sec),
    .lap_min     (lap_min),
    .lap_valid   (lap_valid)
  );

  always #5 clk = ~clk;

  // Stand-in for the seconds/minutes counter chain (0:00 .. 59:59, wraps).
  always @(posedge clk) begin
    if (clr_cnt) begin
      sec_val <= '0;
      min_val <= '0;
    end else if (!pauza) begin
      if (sec_val == 6'd59) begin
        sec_val <= '0;
        min_val <= (min_val == 6'd59) ? 6'd0 : min_val + 6'd1;
      end else begin
        sec_val <= sec_val + 6'd1;
      end
    end
  end

  // Behavioural model: state as 0..3, alarm tracked as cycles left to show.
  int           m_state = 0, n_state = 0;
  int           m_left = 0, n_left = 0;
  bit           m_clr = 0, n_clr = 0;
  bit           m_ps = 0, m_pc = 0, m_pl = 0, n_ps = 0, n_pc = 0, n_pl = 0;
  logic [W-1:0] m_lsec = '0, m_lmin = '0, n_lsec = '0, n_lmin = '0;
  bit           m_lv = 0, n_lv = 0;

  function automatic bit f_hit(int st, logic [W-1:0] s, logic [W-1:0] m,
                               logic [W-1:0] ts, logic [W-1:0] tm);
    return (st == 1) && (s == ts) && (m == tm) && ((ts != 0) || (tm != 0));
  endfunction

  task automatic model_step();
    bit es, ec, el, h;
    n_state = m_state; n_left = m_left; n_clr = 0;
    n_lsec = m_lsec; n_lmin = m_lmin; n_lv = m_lv;
    if (reset) begin
      n_state = 0; n_left = 0; n_clr = 1;
      n_lsec = '0; n_lmin = '0; n_lv = 0;
      n_ps = 0; n_pc = 0; n_pl = 0;
    end else begin
      es = btn_start && !m_ps;
      ec = btn_clear && !m_pc;
      el = btn_lap && !m_pl;
      h  = f_hit(m_state, sec_val, min_val, target_sec, target_min);
      n_ps = btn_start; n_pc = btn_clear; n_pl = btn_lap;
      if (ec) begin
        n_state = 0; n_clr = 1; n_left = 0; n_lv = 0;
      end else begin
        case (m_state)
          0: if (es) n_state = 1;
          1: if (h) begin n_state = 3; n_left = ALARM_TICKS; end
             else if (es) n_state = 2;
          2: if (es) n_state = 1;
          default: begin
            n_left = m_left - 1;
            if (es || n_left <= 0) begin n_state = 0; n_clr = 1; end
          end
        endcase
`ifdef TIMER_LAP_EN
        if (m_state == 1 && !h && el) begin
          n_lsec = sec_val; n_lmin = min_val; n_lv = 1;
        end
`endif
      end
    end
  endtask

  task automatic model_apply();
    m_state = n_state; m_left = n_left; m_clr = n_clr;
    m_ps = n_ps; m_pc = n_pc; m_pl = n_pl;
    m_lsec = n_lsec; m_lmin = n_lmin; m_lv = n_lv;
  endtask

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    check("state",     int'(state),     m_state);
    check("pauza",     int'(pauza),
          int'((m_state != 1) || f_hit(m_state, sec_val, min_val, target_sec, target_min)));
    check("clr_cnt",   int'(clr_cnt),   int'(m_clr));
    check("alarm",     int'(alarm),     int'(m_state == 3));
    check("lap_sec",   int'(lap_sec),   int'(m_lsec));
    check("lap_min",   int'(lap_min),   int'(m_lmin));
    check("lap_valid", int'(lap_valid), int'(m_lv));
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    model_apply();
    compare();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end before 2000000");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int cnt, trans;
    logic [1:0] prev_state;
    logic [W-1:0] s0, m0;
    bit wrapped, any_alarm;

    // Reset
    target_sec = 6'd5; target_min = 6'd0;
    cycle();
    check("rst_state", int'(state), 0);
    check("rst_pauza", int'(pauza), 1);
    check("rst_clr",   int'(clr_cnt), 1);
    check("rst_alarm", int'(alarm), 0);
    check("rst_lapv",  int'(lap_valid), 0);
    reset = 1'b0;
    cycle();
    check("clr_after_rst", int'(clr_cnt), 0);
    $display("reset: state=%0d pauza=%0d", state, pauza);

    // Run to 0:05 target and time the alarm
    btn_start = 1'b1;
    cycle();
    check("start_run", int'(state), 1);
    btn_start = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (sec_val == 6'd5 && state == 2'd1) found = 1;
      else cycle();
    end
    check("reach_target", int'(found), 1);
    check("hit_pauza", int'(pauza), 1);
    cycle();
    check("alarm_enter", int'(state), 3);
    check("sec_frozen", int'(sec_val), 5);
    cnt = 1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (alarm) cnt++;
      else break;
    end
    check("alarm_len", cnt, 10);
    check("alarm_end_clr", int'(clr_cnt), 1);
    check("alarm_end_idle", int'(state), 0);
    cycle();
    check("clr_one_cycle", int'(clr_cnt), 0);
    $display("alarm: high for %0d cycles", cnt);

    // Pause / resume / held button
    target_sec = 6'd0; target_min = 6'd0;
    btn_start = 1'b1; cycle(); check("run2", int'(state), 1);
    btn_start = 1'b0; cycle();
    btn_start = 1'b1; cycle();
    check("pause", int'(state), 2);
    check("pause_pauza", int'(pauza), 1);
    btn_start = 1'b0; cycle();
    btn_start = 1'b1; cycle();
    check("resume", int'(state), 1);
    check("resume_pauza", int'(pauza), 0);
    btn_start = 1'b0; cycle();
    btn_start = 1'b1;
    trans = 0;
    for (int i = 0; i < 20; i++) begin
      prev_state = state;
      cycle();
      if (state != prev_state) trans++;
    end
    check("held_one_trans", trans, 1);
    check("held_state", int'(state), 2);
    btn_start = 1'b0; cycle();
    btn_start = 1'b1; cycle();
    btn_start = 1'b0;
    $display("pause/resume: held transitions=%0d", trans);

    // Free-run wrap with 0:00 target
    s0 = sec_val; m0 = min_val; wrapped = 0; any_alarm = 0;
    for (int i = 0; i < 3600; i++) begin
      cycle();
      if (sec_val == 0 && min_val == 0) wrapped = 1;
      if (alarm) any_alarm = 1;
    end
    check("wrap_sec", int'(sec_val), int'(s0));
    check("wrap_min", int'(min_val), int'(m0));
    check("wrap_state", int'(state), 1);
    check("wrap_no_alarm", int'(any_alarm), 0);
    check("wrap_seen", int'(wrapped), 1);
    $display("wrap: 3600 counts, back at %0d:%0d", min_val, sec_val);

    // Clear and start together in PAUSE
    btn_start = 1'b1; cycle(); check("pause3", int'(state), 2);
    btn_start = 1'b0; cycle();
    btn_start = 1'b1; btn_clear = 1'b1; cycle();
    check("clr_wins_state", int'(state), 0);
    check("clr_wins_pulse", int'(clr_cnt), 1);
    btn_start = 1'b0; btn_clear = 1'b0; cycle();
    check("clr_wins_single", int'(clr_cnt), 0);
    check("start_dropped", int'(state), 0);
    $display("clear+start: state=%0d", state);

    // Lap capture at 1:23
    btn_start = 1'b1; cycle(); btn_start = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (min_val == 6'd1 && sec_val == 6'd23) found = 1;
      else cycle();
    end
    check("reach_1_23", int'(found), 1);
    btn_lap = 1'b1; cycle(); btn_lap = 1'b0;
`ifdef TIMER_LAP_EN
    check("lap_min_1", int'(lap_min), 1);
    check("lap_sec_23", int'(lap_sec), 23);
    check("lap_valid_1", int'(lap_valid), 1);
`else
    check("lap_min_off", int'(lap_min), 0);
    check("lap_sec_off", int'(lap_sec), 0);
    check("lap_valid_off", int'(lap_valid), 0);
`endif
    btn_start = 1'b1; cycle(); btn_start = 1'b0;
    check("lap_pause", int'(state), 2);
    btn_lap = 1'b1; cycle(); btn_lap = 1'b0;
`ifdef TIMER_LAP_EN
    check("lap_pause_keep", int'(lap_sec), 23);
`else
    check("lap_pause_off", int'(lap_sec), 0);
`endif
    btn_clear = 1'b1; cycle(); btn_clear = 1'b0;
    check("lap_clr_valid", int'(lap_valid), 0);
    cycle();
    $display("lap: lap=%0d:%0d valid=%0d", lap_min, lap_sec, lap_valid);

    // Reset during ALARM with 4 cycles left
    target_sec = 6'd3; target_min = 6'd0;
    btn_start = 1'b1; cycle(); btn_start = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (state == 2'd3) found = 1;
      else cycle();
    end
    check("reach_alarm2", int'(found), 1);
    repeat (5) cycle();
    check("still_alarm", int'(alarm), 1);
    reset = 1'b1; cycle(); reset = 1'b0;
    check("rst_alarm_state", int'(state), 0);
    check("rst_alarm_low", int'(alarm), 0);
    check("rst_alarm_clr", int'(clr_cnt), 1);
    cycle();
    check("rst_alarm_clr_end", int'(clr_cnt), 0);
    $display("reset in alarm: state=%0d", state);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0)  btn_start = ~btn_start;
      if ($urandom_range(0, 39) == 0) btn_clear = ~btn_clear;
      if ($urandom_range(0, 5) == 0)  btn_lap = ~btn_lap;
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) begin
        target_sec = 6'($urandom_range(0, 59));
        target_min = 6'($urandom_range(0, 1));
        if ($urandom_range(0, 4) == 0) begin target_sec = '0; target_min = '0; end
      end
      cycle();
    end
    reset = 1'b0;
    $display("random: 4000 cycles done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
